// File: rtl/issue_pkg.sv
// Shared issue-queue package.
// Holds the default tag/data widths, the reservation-station entry layout
// and a few RV32 opcode constants. The integer, mult/div and memory queues
// all build their storage from these types.
package issue_pkg;

   localparam int IQ_TAG_W = 6;
   localparam int IQ_XLEN  = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   typedef struct packed {
      logic [IQ_TAG_W-1:0] tag;
      logic                rdy;
      logic [IQ_XLEN-1:0]  data;
   } iq_src_t;

   typedef struct packed {
      logic                valid;
      logic [IQ_XLEN-1:0]  pc;
      logic [IQ_XLEN-1:0]  imm;
      logic [6:0]          opcode;
      logic [6:0]          funct7;
      logic [2:0]          funct3;
      logic [IQ_TAG_W-1:0] rd_tag;
      iq_src_t             src1;
      iq_src_t             src2;
   } iq_entry_t;

   // True when a waiting source is satisfied by the current CDB broadcast.
   function automatic logic src_wakes(input iq_src_t s, input logic cdb_valid,
                                      input logic [IQ_TAG_W-1:0] cdb_tag);
      return !s.rdy && cdb_valid && (s.tag == cdb_tag);
   endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// Issue bus between an issue queue and its execution unit.
// master : queue side, drives the bundle and issue_valid, samples issue_ready
// slave  : execution-unit side
interface int_issue_queue_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
);
   logic             issue_valid;
   logic             issue_ready;
   logic [XLEN-1:0]  issue_pc;
   logic [XLEN-1:0]  issue_imm;
   logic [XLEN-1:0]  issue_op1;
   logic [XLEN-1:0]  issue_op2;
   logic [6:0]       issue_opcode;
   logic [6:0]       issue_funct7;
   logic [2:0]       issue_funct3;
   logic [TAG_W-1:0] issue_rd_tag;

   modport master (
      output issue_valid, issue_pc, issue_imm, issue_op1, issue_op2,
             issue_opcode, issue_funct7, issue_funct3, issue_rd_tag,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_pc, issue_imm, issue_op1, issue_op2,
             issue_opcode, issue_funct7, issue_funct3, issue_rd_tag,
      output issue_ready
   );
endinterface

// File: rtl/iq_select.sv
// Priority find-first over a request vector.
// req : one bit per queue slot
// idx : index of the lowest set bit (0 when none set)
// hit : at least one bit set
module iq_select #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             hit
);

   // Scan from the top so the lowest index is the last one written.
   always_comb begin
      idx = '0;
      hit = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation-station queue.
// Compacting age-ordered storage (entry 0 oldest). Dispatch writes the next
// free slot, the CDB wakes waiting operands, and the oldest entry with both
// operands ready is presented on the issue bus.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   int_queue_en, disp_*     dispatch write and instruction fields
//   rs1_*/rs2_*, rd_tag      operand tags/ready/data, destination tag
//   int_queue_full           no free entry (registered-state based)
//   cdb_valid/tag/data       common data bus snoop
//   flush                    discard every entry
//   iss                      issue bus (master side)
// TAG_W/XLEN must match the issue_pkg widths used by the entry struct.
module int_issue_queue
   import issue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = IQ_TAG_W,
   parameter int XLEN  = IQ_XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             int_queue_en,
   input  logic             disp_imm,
   input  logic [XLEN-1:0]  disp_pc,
   input  logic [6:0]       opcode,
   input  logic [6:0]       funct7,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  disp_imm_val,
   input  logic [TAG_W-1:0] rd_tag,
   input  logic [TAG_W-1:0] rs1_tag,
   input  logic [TAG_W-1:0] rs2_tag,
   input  logic             rs1_rdy,
   input  logic             rs2_rdy,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   output logic             int_queue_full,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_data,
   input  logic             flush,
   int_issue_queue_if.master iss
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   iq_entry_t entries_q [DEPTH];
   iq_entry_t entries_d [DEPTH];
   iq_entry_t woken     [DEPTH+1];
   iq_entry_t new_entry;
   iq_entry_t sel_e;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] wr_idx;
   logic [DEPTH-1:0] rdy_vec;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_hit;
   logic             pop;
   logic             disp_ok;

   // Occupancy and ready vector come from registered state only, so full
   // and the issue bundle have no combinational path from dispatch or CDB.
   always_comb begin
      cnt     = '0;
      rdy_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt        = cnt + CNT_W'(entries_q[i].valid);
         rdy_vec[i] = entries_q[i].valid & entries_q[i].src1.rdy & entries_q[i].src2.rdy;
      end
   end

   assign int_queue_full = (cnt == CNT_W'(DEPTH));

   iq_select #(.N(DEPTH), .IDX_W(IDX_W)) u_sel (
      .req (rdy_vec),
      .idx (sel_idx),
      .hit (sel_hit)
   );

   assign pop     = sel_hit & iss.issue_ready;
   assign disp_ok = int_queue_en & ~int_queue_full;

   // Incoming entry, including the same-cycle CDB bypass.
   always_comb begin
      new_entry           = '0;
      new_entry.valid     = 1'b1;
      new_entry.pc        = disp_pc;
      new_entry.imm       = disp_imm_val;
      new_entry.opcode    = opcode;
      new_entry.funct7    = funct7;
      new_entry.funct3    = funct3;
      new_entry.rd_tag    = rd_tag;
      new_entry.src1.tag  = rs1_tag;
      new_entry.src1.rdy  = rs1_rdy;
      new_entry.src1.data = rs1_data;
      new_entry.src2.tag  = rs2_tag;
      new_entry.src2.rdy  = rs2_rdy;
      new_entry.src2.data = rs2_data;
      if (src_wakes(new_entry.src1, cdb_valid, cdb_tag)) begin
         new_entry.src1.rdy  = 1'b1;
         new_entry.src1.data = cdb_data;
      end
      if (disp_imm) begin
         new_entry.src2.rdy  = 1'b1;
         new_entry.src2.data = disp_imm_val;
      end else if (src_wakes(new_entry.src2, cdb_valid, cdb_tag)) begin
         new_entry.src2.rdy  = 1'b1;
         new_entry.src2.data = cdb_data;
      end
   end

   // Wakeup on pre-shift positions, then compaction, then dispatch write.
   // woken has one extra empty slot so the top entry shifts in zeros.
   always_comb begin
      for (int i = 0; i <= DEPTH; i++) begin
         woken[i] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         woken[i] = entries_q[i];
         if (woken[i].valid && src_wakes(woken[i].src1, cdb_valid, cdb_tag)) begin
            woken[i].src1.rdy  = 1'b1;
            woken[i].src1.data = cdb_data;
         end
         if (woken[i].valid && src_wakes(woken[i].src2, cdb_valid, cdb_tag)) begin
            woken[i].src2.rdy  = 1'b1;
            woken[i].src2.data = cdb_data;
         end
      end

      for (int i = 0; i < DEPTH; i++) begin
         if (pop && (i >= int'(sel_idx))) begin
            entries_d[i] = woken[i+1];
         end else begin
            entries_d[i] = woken[i];
         end
      end

      // The queue is compact, so the first free slot is the occupancy count
      // (one lower when an entry leaves this edge).
      wr_idx = pop ? (cnt - CNT_W'(1)) : cnt;
      if (disp_ok) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == wr_idx) begin
               entries_d[i] = new_entry;
            end
         end
      end

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

   // Empty selection drives an all-zero bundle.
   always_comb begin
      sel_e = entries_q[sel_idx];
      if (!sel_hit) begin
         sel_e = '0;
      end
   end

   assign iss.issue_valid  = sel_hit;
   assign iss.issue_pc     = sel_e.pc;
   assign iss.issue_imm    = sel_e.imm;
   assign iss.issue_op1    = sel_e.src1.data;
   assign iss.issue_op2    = sel_e.src2.data;
   assign iss.issue_opcode = sel_e.opcode;
   assign iss.issue_funct7 = sel_e.funct7;
   assign iss.issue_funct3 = sel_e.funct3;
   assign iss.issue_rd_tag = sel_e.rd_tag;

   // Dispatch into a full queue is dropped by disp_ok; flag the violation.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(int_queue_en && int_queue_full))
            else $warning("int_issue_queue: dispatch while full was dropped");
      end
   end

endmodule
